matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning rows fetched from input_controller per job.
REQ-002 SHALL have parameter COLS, default 4, meaning result columns computed per row.
REQ-003 SHALL have parameter RDY_TIMEOUT, default 16, meaning maximum WAIT_RDY cycles before error.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 load_done  input  1  one-cycle pulse from input_controller start output; 32 bytes are loaded.
REQ-007 input_ready  input  1  input_controller element1..4 valid this cycle.
REQ-008 data_valid  input  1  byte-load strobe, monitored only, shared with input_controller.
REQ-009 result_ack  input  1  downstream accepts current result.
REQ-010 input_start  output  1  one-cycle row-fetch request to input_controller.
REQ-011 row_idx  output  $clog2(ROWS)  current row.
REQ-012 col_sel  output  $clog2(COLS)  coefficient column select for MAC datapath.
REQ-013 mac_en  output  1  MAC computes C[row_idx][col_sel] this cycle.
REQ-014 result_valid  output  1  MAC result held for downstream.
REQ-015 busy  output  1  job in progress.
REQ-016 done  output  1  one-cycle pulse after final result accepted.
REQ-017 err  output  1  sticky protocol/timeout error.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, WAIT_RDY, CALC, OUT.
REQ-019 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.
REQ-020 IDLE: on load_done=1, clear row_idx, col_sel and err, then go to FETCH.
REQ-021 FETCH: input_start=1 for exactly this one cycle, then go to WAIT_RDY unconditionally.
REQ-022 WAIT_RDY: on input_ready=1, go to CALC with col_sel=0; otherwise increment the timeout counter.
REQ-023 WAIT_RDY timeout: when the counter reaches RDY_TIMEOUT without input_ready, set err=1 and return to IDLE without a done pulse.
REQ-024 CALC: mac_en=1 for exactly one cycle, then go to OUT.
REQ-025 OUT: result_valid=1, held with stable row_idx/col_sel until result_ack=1 (backpressure of unbounded duration).
REQ-026 On ack with col_sel<COLS-1: increment col_sel and go to CALC.
REQ-027 On ack with col_sel=COLS-1 and row_idx<ROWS-1: increment row_idx, set col_sel=0 and go to FETCH.
REQ-028 On ack at the last row and last column: go to IDLE and pulse done=1 for one cycle.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 load_done while busy SHALL be ignored; no restart or queuing.
REQ-031 data_valid=1 in any state except IDLE SHALL set err=1 (it corrupts row rotation); the job SHALL continue.
REQ-032 input_ready seen outside WAIT_RDY SHALL be ignored.
REQ-033 The input_controller rotates its registers on each fetch, so after ROWS fetches it returns to its original state; the sequencer SHALL NOT issue more than ROWS input_start pulses per job.
REQ-034 Counters SHALL be exactly sized; row_idx/col_sel never wrap mid-job.
REQ-035 Cycle cost with result_ack held high SHALL be 2+2*COLS cycles per row (10 at default).

Reset
REQ-036 reset_n=0 SHALL asynchronously force IDLE and clear all outputs and counters to 0 (input_start, mac_en, result_valid, busy, done, err, row_idx, col_sel).
REQ-037 Reset asserted mid-job SHALL abort the job without a done pulse; operation resumes only on a new load_done.

Structure
REQ-038 The FSM state enum and the ROWS/COLS/RDY_TIMEOUT defaults SHALL reside in shared package etin35_pkg.
REQ-039 The block SHALL be a single module with no sub-modules; it instantiates neither input_controller nor the MAC.

Verification
REQ-040 Nominal job: load_done pulse at cycle 0 with result_ack tied 1 and input_ready one cycle after each input_start -> 8 input_start pulses, 32 mac_en pulses, done at cycle 81, err=0.
REQ-041 Backpressure: hold result_ack=0 for 5 cycles at row 3, col 2 -> result_valid, row_idx=3 and col_sel=2 stay stable; no extra mac_en; job length grows by 5 cycles.
REQ-042 Timeout: input_ready never asserted -> err=1 after 16 WAIT_RDY cycles, state IDLE, busy=0, no done.
REQ-043 Protocol error: data_valid pulse during CALC of row 1 -> err=1 from the next cycle; job still completes with a done pulse.
REQ-044 Reset mid-job: reset_n low during OUT of row 5 -> all outputs 0 immediately; a later load_done starts a fresh job at row 0.
REQ-045 Ignored restart: load_done pulse while busy -> no state change; exactly one done pulse per job.

Source files
------------

// File: rtl/etin35_pkg.sv
// Shared definitions for the matmul sequencing logic.
//   seq_state_e      : sequencer FSM states
//   *_DEF localparams: default job geometry and ready timeout
package etin35_pkg;

    localparam int ROWS_DEF        = 8;   // rows fetched per job
    localparam int COLS_DEF        = 4;   // result columns per row
    localparam int RDY_TIMEOUT_DEF = 16;  // max WAIT_RDY cycles before error

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_RDY = 3'd2,
        CALC     = 3'd3,
        OUT      = 3'd4
    } seq_state_e;

endpackage

// File: rtl/matmul_sequencer.sv
// matmul_sequencer
// Steps a MAC datapath through a ROWS x COLS result matrix. Each row is
// fetched from the input_controller (input_start / input_ready handshake),
// then every column is computed (mac_en) and presented downstream
// (result_valid) until accepted (result_ack).
//
// Ports
//   clk           in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   load_done     in   start a job (ignored while busy)
//   input_ready   in   input_controller elements valid (only used in WAIT_RDY)
//   data_valid    in   byte-load strobe; seen during a job it flags err
//   result_ack    in   downstream accepts the current result
//   input_start   out  one-cycle row-fetch request
//   row_idx       out  current row
//   col_sel       out  current coefficient column
//   mac_en        out  MAC computes C[row_idx][col_sel] this cycle
//   result_valid  out  MAC result held for downstream
//   busy          out  job in progress
//   done          out  one-cycle pulse after the final result is accepted
//   err           out  sticky protocol / timeout error
module matmul_sequencer
    import etin35_pkg::*;
#(
    parameter int ROWS        = ROWS_DEF,
    parameter int COLS        = COLS_DEF,
    parameter int RDY_TIMEOUT = RDY_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_done,
    input  logic                     input_ready,
    input  logic                     data_valid,
    input  logic                     result_ack,
    output logic                     input_start,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic [$clog2(COLS)-1:0]  col_sel,
    output logic                     mac_en,
    output logic                     result_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    // One extra count value so the counter can represent RDY_TIMEOUT itself.
    localparam int TMO_W = $clog2(RDY_TIMEOUT + 1);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RDY_TIMEOUT - 1);

    seq_state_e        state_reg, state_next;
    logic [ROW_W-1:0]  row_reg,   row_next;
    logic [COL_W-1:0]  col_reg,   col_next;
    logic [TMO_W-1:0]  tmo_reg,   tmo_next;
    logic              err_reg,   err_next;
    logic              done_reg,  done_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            col_reg   <= '0;
            tmo_reg   <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            tmo_reg   <= tmo_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        tmo_next   = tmo_reg;
        err_next   = err_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (load_done) begin
                    row_next   = '0;
                    col_next   = '0;
                    err_next   = 1'b0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // Fresh timeout window for every row fetch.
                tmo_next   = '0;
                state_next = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (input_ready) begin
                    col_next   = '0;
                    state_next = CALC;
                end else if (tmo_reg == TMO_LAST) begin
                    // This is the RDY_TIMEOUT-th cycle without ready: abort.
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            CALC: begin
                state_next = OUT;
            end
            OUT: begin
                if (result_ack) begin
                    if (col_reg != COL_LAST) begin
                        col_next   = col_reg + 1'b1;
                        state_next = CALC;
                    end else if (row_reg != ROW_LAST) begin
                        row_next   = row_reg + 1'b1;
                        col_next   = '0;
                        state_next = FETCH;
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A byte load during a job shifts the input_controller rotation out
        // of step with row_idx; flag it but let the job run to the end.
        if (state_reg != IDLE && data_valid) begin
            err_next = 1'b1;
        end
    end

    // All outputs come straight from registers or a decode of state_reg.
    assign input_start  = (state_reg == FETCH);
    assign mac_en       = (state_reg == CALC);
    assign result_valid = (state_reg == OUT);
    assign busy         = (state_reg != IDLE);
    assign row_idx      = row_reg;
    assign col_sel      = col_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer. Each job pushes the event stream the
// job should produce (row fetches, MAC steps, accepted results, done with its
// err value) into a queue; a negedge monitor pops and compares as the DUT
// shows events. A responder answers fetches and results with random delays.
module tb_matmul_sequencer;

    localparam int ROWS        = 8;
    localparam int COLS        = 4;
    localparam int RDY_TIMEOUT = 16;

    logic                    clk;
    logic                    reset_n;
    logic                    load_done;
    logic                    input_ready;
    logic                    data_valid;
    logic                    result_ack;
    logic                    input_start;
    logic [$clog2(ROWS)-1:0] row_idx;
    logic [$clog2(COLS)-1:0] col_sel;
    logic                    mac_en;
    logic                    result_valid;
    logic                    busy;
    logic                    done;
    logic                    err;

    matmul_sequencer #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .RDY_TIMEOUT (RDY_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_done    (load_done),
        .input_ready  (input_ready),
        .data_valid   (data_valid),
        .result_ack   (result_ack),
        .input_start  (input_start),
        .row_idx      (row_idx),
        .col_sel      (col_sel),
        .mac_en       (mac_en),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef enum int {EV_START, EV_MAC, EV_ACK, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       row;
        int       col;
        bit       err;
    } ev_t;

    ev_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Responder configuration shared with the stimulus.
    bit rdy_en   = 1'b1;
    int rdy_max  = 0;
    int ack_max  = 0;
    bit bp_on    = 1'b0;
    bit noise_en = 1'b0;
    int dv_row   = -1;
    bit dv_sent  = 1'b0;
    bit dv_check = 1'b0;
    int extra    = 0;   // cycles added by the responder's delays

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_checks++;
        $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model: expected event stream ----------------
    task automatic push_job(input bit ready_on, input bit exp_err);
        if (!ready_on) begin
            exp_q.push_back('{EV_START, 0, 0, 1'b0});
            return;
        end
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back('{EV_START, r, 0, 1'b0});
            for (int c = 0; c < COLS; c++) begin
                exp_q.push_back('{EV_MAC, r, c, 1'b0});
                exp_q.push_back('{EV_ACK, r, c, 1'b0});
            end
        end
        exp_q.push_back('{EV_DONE, ROWS - 1, COLS - 1, exp_err});
    endtask

    // ---------------- monitor ----------------
    task automatic expect_ev(input ev_kind_e k, input bit pop);
        ev_t e;
        if (exp_q.size() == 0) begin
            fail_now("unexpected_event", int'(k), -1);
            return;
        end
        e = exp_q[0];
        check("ev_kind", int'(k), int'(e.kind));
        check("ev_row", int'(row_idx), e.row);
        check("ev_col", int'(col_sel), e.col);
        if (k == EV_DONE) check("done_err", int'(err), int'(e.err));
        if (k != EV_ACK || pop || e.kind != k) void'(exp_q.pop_front());
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset_n) continue;
            if (input_start || mac_en || result_valid) check("busy_active", int'(busy), 1);
            if (input_start)  expect_ev(EV_START, 1'b1);
            if (mac_en)       expect_ev(EV_MAC, 1'b1);
            if (result_valid) expect_ev(EV_ACK, result_ack);
            if (done)         expect_ev(EV_DONE, 1'b1);
        end
    end

    // ---------------- responder ----------------
    initial begin : responder
        int rdy_cnt;
        int ack_cnt;
        rdy_cnt     = -1;
        ack_cnt     = -1;
        input_ready = 1'b0;
        result_ack  = 1'b0;
        data_valid  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            input_ready = 1'b0;
            result_ack  = 1'b0;
            data_valid  = 1'b0;
            if (!reset_n) begin
                rdy_cnt  = -1;
                ack_cnt  = -1;
                dv_check = 1'b0;
                continue;
            end
            if (dv_check) begin
                check("err_after_dv", int'(err), 1);
                dv_check = 1'b0;
            end
            if (rdy_cnt == 0) begin
                input_ready = 1'b1;
                rdy_cnt     = -1;
            end else if (rdy_cnt > 0) begin
                rdy_cnt--;
            end
            if (input_start && rdy_en) begin
                rdy_cnt = int'($urandom_range(rdy_max, 0));
                extra  += rdy_cnt;
            end
            if ((mac_en || result_valid) && noise_en) input_ready = 1'($urandom_range(1, 0));
            if (result_valid) begin
                if (ack_cnt < 0) begin
                    if (bp_on && int'(row_idx) == 3 && int'(col_sel) == 2) ack_cnt = 5;
                    else ack_cnt = int'($urandom_range(ack_max, 0));
                    extra += ack_cnt;
                end
                if (ack_cnt == 0) begin
                    result_ack = 1'b1;
                    ack_cnt    = -1;
                end else begin
                    ack_cnt--;
                end
            end
            if (dv_row >= 0 && !dv_sent && mac_en && int'(row_idx) == dv_row) begin
                data_valid = 1'b1;
                dv_sent    = 1'b1;
                dv_check   = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    int job_no = 0;

    task automatic run_job(input string name, input bit ready_on, input int rmax,
                           input int amax, input bit bp, input int dvrow,
                           input bit restart, input int rst_row);
        int n;
        int exp_n;
        rdy_en   = ready_on;
        rdy_max  = rmax;
        ack_max  = amax;
        bp_on    = bp;
        noise_en = restart;
        dv_row   = dvrow;
        dv_sent  = 1'b0;
        extra    = 0;
        job_no++;
        push_job(ready_on, dvrow >= 0);
        @(posedge clk);
        #1;
        load_done = 1'b1;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            load_done = 1'b0;
            n++;
            if (restart && busy && $urandom_range(7, 0) == 0) load_done = 1'b1;
            if (rst_row >= 0 && result_valid && int'(row_idx) == rst_row) begin
                #2;
                reset_n   = 1'b0;
                load_done = 1'b0;
                #1;
                check("rst_input_start", int'(input_start), 0);
                check("rst_mac_en", int'(mac_en), 0);
                check("rst_result_valid", int'(result_valid), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_err", int'(err), 0);
                check("rst_row_idx", int'(row_idx), 0);
                check("rst_col_sel", int'(col_sel), 0);
                exp_q.delete();
                repeat (2) @(posedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                check("post_rst_busy", int'(busy), 0);
                check("post_rst_queue", exp_q.size(), 0);
                $display("job %0d %s: reset at row %0d after %0d cycles", job_no, name, rst_row, n);
                return;
            end
            if (ready_on && done) break;
            if (!ready_on && !busy) break;
            if (n > 2000) begin
                fail_now("job_cycle_budget", n, 2000);
                break;
            end
        end
        if (ready_on) begin
            exp_n = 1 + ROWS * (2 + 2 * COLS) + extra;
            check("done_cycle", n, exp_n);
        end else begin
            check("timeout_cycle", n, 2 + RDY_TIMEOUT);
            check("timeout_err", int'(err), 1);
            check("timeout_busy", int'(busy), 0);
            check("timeout_done", int'(done), 0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("idle_busy", int'(busy), 0);
        $display("job %0d %s: %0d cycles, extra %0d, err %0d", job_no, name, n, extra, int'(err));
    endtask

    initial begin : stimulus
        reset_n   = 1'b0;
        load_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_input_start", int'(input_start), 0);
        check("reset_mac_en", int'(mac_en), 0);
        check("reset_result_valid", int'(result_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        check("reset_row_idx", int'(row_idx), 0);
        check("reset_col_sel", int'(col_sel), 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_job("nominal", 1'b1, 0, 0, 1'b0, -1, 1'b0, -1);
        run_job("backpressure", 1'b1, 0, 0, 1'b1, -1, 1'b0, -1);
        run_job("timeout", 1'b0, 0, 0, 1'b0, -1, 1'b0, -1);
        run_job("after_timeout", 1'b1, 2, 2, 1'b0, -1, 1'b0, -1);
        run_job("protocol_err", 1'b1, 0, 0, 1'b0, 1, 1'b0, -1);
        run_job("reset_midjob", 1'b1, 1, 1, 1'b0, -1, 1'b0, 5);
        run_job("fresh_after_reset", 1'b1, 0, 0, 1'b0, -1, 1'b0, -1);
        run_job("restart_noise", 1'b1, 2, 3, 1'b0, -1, 1'b1, -1);
        for (int j = 0; j < 4; j++) begin
            run_job("random", 1'b1, 3, 3, 1'b0, int'($urandom_range(ROWS - 1, 0)), 1'b1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
